// File: rtl/ser_pkg.sv
// Shared definitions for serializer32: state encoding, default width, counter sizing.
package ser_pkg;

    localparam int SER_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser_state_e;

    // Bits needed to count 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/serializer32_if.sv
// Load and serial-stream handshake bundle for serializer32.
interface serializer32_if
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             sdo;
    logic             sdo_valid;
    logic             sdo_ready;
    logic             sdo_last;

    modport master (
        output load_valid, load_data, sdo_ready,
        input  load_ready, sdo, sdo_valid, sdo_last
    );

    modport slave (
        input  load_valid, load_data, sdo_ready,
        output load_ready, sdo, sdo_valid, sdo_last
    );
endinterface

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register; parallel load wins over shift, zero fill.
module shift_reg_piso #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             sout
);
    logic [WIDTH-1:0] sreg_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_p0 <= '0;
        end else if (load) begin
            sreg_p0 <= load_data;
        end else if (shift_en) begin
            sreg_p0 <= MSB_FIRST ? {sreg_p0[WIDTH-2:0], 1'b0} : {1'b0, sreg_p0[WIDTH-1:1]};
        end
    end

    assign sout = MSB_FIRST ? sreg_p0[WIDTH-1] : sreg_p0[0];
endmodule

// File: rtl/serializer32.sv
// Word-to-bit-stream transmitter with valid/ready on both sides.
// Define SERIALIZER32_PARITY_EN to append an even-parity beat to every frame.
module serializer32
    import ser_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    serializer32_if.slave bus
);
    localparam int               CNT_W   = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    ser_state_e       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             sout;
    logic             final_data;
    logic             frame_done;
    logic             load_ready;
    logic             load_acc;
    logic             shift_en;

    assign final_data = (state == ST_SHIFT) && (cnt == CNT_MAX);
    assign shift_en   = (state == ST_SHIFT) && bus.sdo_ready;

`ifdef SERIALIZER32_PARITY_EN
    logic par_q;
    assign frame_done = (state == ST_PARITY) && bus.sdo_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load_acc) begin
            par_q <= ^bus.load_data;
        end
    end
`else
    assign frame_done = final_data && bus.sdo_ready;
`endif

    // The final beat completing this cycle frees the register for the next word.
    assign load_ready = (state == ST_IDLE) || frame_done;
    assign load_acc   = bus.load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (load_acc) state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (final_data && bus.sdo_ready) begin
`ifdef SERIALIZER32_PARITY_EN
                    state_n = ST_PARITY;
`else
                    state_n = load_acc ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
            ST_PARITY: begin
                if (bus.sdo_ready) state_n = load_acc ? ST_SHIFT : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load_acc) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end
    end

    shift_reg_piso #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sreg (
        .clk       (clk),
        .reset     (reset),
        .load      (load_acc),
        .load_data (bus.load_data),
        .shift_en  (shift_en),
        .sout      (sout)
    );

    always_comb begin
        bus.sdo = 1'b0;
        if (state == ST_SHIFT) begin
            bus.sdo = sout;
        end
`ifdef SERIALIZER32_PARITY_EN
        else if (state == ST_PARITY) begin
            bus.sdo = par_q;
        end
`endif
    end

    assign bus.sdo_valid  = (state != ST_IDLE);
    assign bus.load_ready = load_ready;
`ifdef SERIALIZER32_PARITY_EN
    assign bus.sdo_last   = (state == ST_PARITY);
`else
    assign bus.sdo_last   = final_data;
`endif
endmodule

// File: tb/tb_serializer32.sv
// Bench for serializer32: MSB-first and LSB-first instances share one stimulus and one
// frame-level model. Honours SERIALIZER32_PARITY_EN.
module tb_serializer32;
    localparam int W = 32;
`ifdef SERIALIZER32_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct {
        logic [31:0] word;
        int          len;
        logic        par;
    } frame_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   run = 0;

    serializer32_if #(.WIDTH(W)) ifa ();
    serializer32_if #(.WIDTH(W)) ifb ();

    serializer32 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    serializer32 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: remaining beats of the frame in flight, in transmission order.
    logic qa[$];
    logic qb[$];
    logic mdl_lr;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                qa.delete();
                qb.delete();
            end else begin
                mdl_lr = (qa.size() == 0) || (qa.size() == 1 && ifa.sdo_ready);
                if (qa.size() != 0 && ifa.sdo_ready) begin
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                end
                if (ifa.load_valid && mdl_lr) begin
                    for (int i = 0; i < W; i++) begin
                        qa.push_back(ifa.load_data[W-1-i]);
                        qb.push_back(ifa.load_data[i]);
                    end
`ifdef SERIALIZER32_PARITY_EN
                    qa.push_back(^ifa.load_data);
                    qb.push_back(^ifa.load_data);
`endif
                end
            end
        end
    end

    // Per-cycle compare and frame capture.
    logic   exp_a, exp_b, exp_v, exp_last, exp_lr;
    logic   bufa[$];
    logic   bufb[$];
    frame_t frames_a[$];
    frame_t frames_b[$];
    frame_t f;

    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                exp_v    = (qa.size() != 0);
                exp_a    = 1'b0;
                exp_b    = 1'b0;
                if (exp_v) begin
                    exp_a = qa[0];
                    exp_b = qb[0];
                end
                exp_last = (qa.size() == 1);
                exp_lr   = !exp_v || (exp_last && ifa.sdo_ready);
                check("a_sdo",        {31'd0, ifa.sdo},        {31'd0, exp_a});
                check("a_sdo_valid",  {31'd0, ifa.sdo_valid},  {31'd0, exp_v});
                check("a_sdo_last",   {31'd0, ifa.sdo_last},   {31'd0, exp_last});
                check("a_load_ready", {31'd0, ifa.load_ready}, {31'd0, exp_lr});
                check("b_sdo",        {31'd0, ifb.sdo},        {31'd0, exp_b});
                check("b_sdo_valid",  {31'd0, ifb.sdo_valid},  {31'd0, exp_v});
                check("b_sdo_last",   {31'd0, ifb.sdo_last},   {31'd0, exp_last});
                check("b_load_ready", {31'd0, ifb.load_ready}, {31'd0, exp_lr});

                if (reset) begin
                    bufa.delete();
                    bufb.delete();
                end else begin
                    if (ifa.sdo_valid && ifa.sdo_ready) begin
                        bufa.push_back(ifa.sdo);
                        if (ifa.sdo_last) begin
                            f.word = '0;
                            for (int i = 0; i < W && i < bufa.size(); i++) f.word[W-1-i] = bufa[i];
                            f.len = bufa.size();
                            f.par = (bufa.size() > W) ? bufa[W] : 1'b0;
                            frames_a.push_back(f);
                            bufa.delete();
                        end
                    end
                    if (ifb.sdo_valid && ifb.sdo_ready) begin
                        bufb.push_back(ifb.sdo);
                        if (ifb.sdo_last) begin
                            f.word = '0;
                            for (int i = 0; i < W && i < bufb.size(); i++) f.word[i] = bufb[i];
                            f.len = bufb.size();
                            f.par = (bufb.size() > W) ? bufb[W] : 1'b0;
                            frames_b.push_back(f);
                            bufb.delete();
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        ifa.load_valid = v;  ifb.load_valid = v;
        ifa.load_data  = d;  ifb.load_data  = d;
        ifa.sdo_ready  = r;  ifb.sdo_ready  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; load_valid stays high afterwards.
    task automatic load_word(input logic [31:0] d);
        logic ok;
        ifa.load_valid = 1'b1;  ifb.load_valid = 1'b1;
        ifa.load_data  = d;     ifb.load_data  = d;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = ifa.load_ready;
            tick();
        end
        check("load_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (ifa.sdo_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", {31'd0, ifa.sdo_valid}, 32'd0);
        tick();
    endtask

    task automatic expect_frame(input string nm, input logic [31:0] w);
        frame_t fa, fb;
        check({nm, "_a_present"}, {31'd0, frames_a.size() != 0}, 32'd1);
        check({nm, "_b_present"}, {31'd0, frames_b.size() != 0}, 32'd1);
        if (frames_a.size() != 0 && frames_b.size() != 0) begin
            fa = frames_a.pop_front();
            fb = frames_b.pop_front();
            check({nm, "_a_word"}, fa.word, w);
            check({nm, "_b_word"}, fb.word, w);
            check({nm, "_a_len"}, fa.len, FL);
            check({nm, "_b_len"}, fb.len, FL);
`ifdef SERIALIZER32_PARITY_EN
            check({nm, "_a_par"}, {31'd0, fa.par}, {31'd0, ^w});
            check({nm, "_b_par"}, {31'd0, fb.par}, {31'd0, ^w});
`endif
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_load_ready"}, {31'd0, ifa.load_ready}, 32'd1);
        check({nm, "_sdo_valid"},  {31'd0, ifa.sdo_valid},  32'd0);
        check({nm, "_sdo"},        {31'd0, ifa.sdo},        32'd0);
        check({nm, "_sdo_last"},   {31'd0, ifa.sdo_last},   32'd0);
        check({nm, "_b_sdo_valid"}, {31'd0, ifb.sdo_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b1);
        tick();
        tick();
        run = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
        tick();
        reset = 1'b0;

        // Single word, MSB first on dut_a; same stream reversed on dut_b.
        frames_a.delete(); frames_b.delete();
        load_word(32'h8000_0001);
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
        wait_idle();
        expect_frame("single", 32'h8000_0001);

        // Backpressure: stall three cycles while beat 5 is presented.
        load_word(32'hA5A5_A5A5);
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
        repeat (5) tick();
        ifa.sdo_ready = 1'b0; ifb.sdo_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_a_beat5", {31'd0, ifa.sdo}, 32'd1);
            check("stall_b_beat5", {31'd0, ifb.sdo}, 32'd1);
            tick();
        end
        ifa.sdo_ready = 1'b1; ifb.sdo_ready = 1'b1;
        wait_idle();
        expect_frame("bp", 32'hA5A5_A5A5);

        // Back-to-back words with load_valid held high.
        load_word(32'hFFFF_FFFF);
        load_word(32'h0000_0000);
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
        wait_idle();
        expect_frame("b2b_first", 32'hFFFF_FFFF);
        expect_frame("b2b_second", 32'h0000_0000);

        // Low two bits set: dut_b must lead with two ones.
        load_word(32'h0000_0003);
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
        @(negedge clk);
        check("lsb_first_bit0", {31'd0, ifb.sdo}, 32'd1);
        tick();
        @(negedge clk);
        check("lsb_first_bit1", {31'd0, ifb.sdo}, 32'd1);
        tick();
        wait_idle();
        expect_frame("lsb", 32'h0000_0003);

        // Reset mid-frame, then a clean frame.
        load_word(32'hDEAD_BEEF);
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_idle_outputs("midreset");
        check("midreset_no_frame", frames_a.size(), 32'd0);
        tick();
        reset = 1'b0;
        load_word(32'h1234_5678);
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
        wait_idle();
        expect_frame("after_reset", 32'h1234_5678);

`ifdef SERIALIZER32_PARITY_EN
        load_word(32'h0000_0007);
        ifa.load_valid = 1'b0; ifb.load_valid = 1'b0;
        repeat (W) tick();
        @(negedge clk);
        check("parity_beat_sdo",  {31'd0, ifa.sdo},      32'd1);
        check("parity_beat_last", {31'd0, ifa.sdo_last}, 32'd1);
        tick();
        wait_idle();
        expect_frame("parity", 32'h0000_0007);
`endif

        // Random traffic with occasional resets; the per-cycle model does the checking.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
